// File: rtl/prog_monitor_pkg.sv
// Shared types and constants for the program-loader / debug-monitor front end.
// Display nibble positions are named here so the top and sseg wiring agree.
package prog_monitor_pkg;

  typedef enum logic [1:0] {
    LD_IDLE    = 2'd0,
    LD_WRITE   = 2'd1,
    LD_ADVANCE = 2'd2
  } ld_state_e;

  localparam logic MODE_PROG = 1'b1;
  localparam logic MODE_RUN  = 1'b0;

  // Digit order on the 4-digit display, digit 3 is leftmost.
  localparam int NIB_ADRS_HI = 3;
  localparam int NIB_ADRS_LO = 2;
  localparam int NIB_DATA_HI = 1;
  localparam int NIB_DATA_LO = 0;

  localparam int DP_FLASH = 0;
  localparam int DP_OWNER = 3;

  function automatic int nib_lsb(input int idx);
    return idx * 4;
  endfunction

endpackage

// File: rtl/prog_monitor_ctrl_btn_debounce.sv
// Two-flop synchroniser plus stability counter for one active-low button.
// press pulses for one cycle when the accepted level falls to 0.
module btn_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  localparam int            CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      // Counter tracks how long the synced level has disagreed with the accepted one.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        press_q <= ~sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/prog_monitor_ctrl.sv
// Program loader, memory bus mux and 7-seg nibble source in front of the CPU.
// Buttons load an address or write switch data; mode selects bus ownership.
module prog_monitor_ctrl
  import prog_monitor_pkg::*;
#(
  parameter int AW           = 8,
  parameter int DW           = 8,
  parameter int NRES         = 4,
  parameter int DEB_CYCLES   = 50000,
  parameter int FLASH_CYCLES = 2000000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mode,
  input  logic                     step_btn_n,
  input  logic                     load_btn_n,
  input  logic [7:0]               data_sw,
  input  logic [$clog2(NRES)-1:0]  res_sel,
  input  logic [7:0]               resdt,
  input  logic [AW-1:0]            cpu_adrs,
  input  logic [DW-1:0]            cpu_data,
  input  logic                     cpu_wr_en,
  output logic [7:0]               resad,
  output logic                     cpu_run_en,
  output logic [AW-1:0]            mem_adrs,
  output logic [DW-1:0]            mem_data,
  output logic                     mem_wr_en,
  output logic [15:0]              disp_nib,
  output logic [3:0]               disp_dp
);

  localparam int            RSW        = $clog2(NRES);
  localparam int            FW         = $clog2(FLASH_CYCLES + 1);
  localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_CYCLES);

  logic          step_press, load_press;
  logic          mode_s1_q, mode_q;
  ld_state_e     state_q;
  logic [AW-1:0] prog_adrs_q;
  logic [DW-1:0] wr_data_q;
  logic          owner_prog_q;
  logic [FW-1:0] flash_q;
  logic [7:0]    resad_w, adrs_ext, data_ext;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
    .clock (clock),
    .reset (reset),
    .btn_n (step_btn_n),
    .press (step_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_load_deb (
    .clock (clock),
    .reset (reset),
    .btn_n (load_btn_n),
    .press (load_press)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_s1_q <= MODE_RUN;
      mode_q    <= MODE_RUN;
    end else begin
      mode_s1_q <= mode;
      mode_q    <= mode_s1_q;
    end
  end

  // Ownership only changes in IDLE so a write sequence always completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= LD_IDLE;
      prog_adrs_q  <= '0;
      wr_data_q    <= '0;
      owner_prog_q <= 1'b0;
      flash_q      <= '0;
    end else begin
      if (flash_q != '0) flash_q <= flash_q - FW'(1);
      case (state_q)
        LD_IDLE: begin
          owner_prog_q <= mode_q;
          if (mode_q == MODE_PROG) begin
            if (load_press) begin
              prog_adrs_q <= data_sw[AW-1:0];
            end else if (step_press) begin
              wr_data_q <= data_sw[DW-1:0];
              state_q   <= LD_WRITE;
            end
          end
        end
        LD_WRITE: state_q <= LD_ADVANCE;
        LD_ADVANCE: begin
          prog_adrs_q <= prog_adrs_q + AW'(1);
          flash_q     <= FLASH_LOAD;
          state_q     <= LD_IDLE;
        end
        default: state_q <= LD_IDLE;
      endcase
    end
  end

  always_comb begin
    resad_w                = '0;
    resad_w[RSW-1:0]       = res_sel;
    adrs_ext               = '0;
    adrs_ext[AW-1:0]       = prog_adrs_q;
    data_ext               = '0;
    data_ext[DW-1:0]       = wr_data_q;
  end

  always_comb begin
    if (owner_prog_q) begin
      mem_adrs  = prog_adrs_q;
      mem_data  = wr_data_q;
      mem_wr_en = (state_q == LD_WRITE);
    end else begin
      mem_adrs  = cpu_adrs;
      mem_data  = cpu_data;
      mem_wr_en = cpu_wr_en;
    end
  end

  always_comb begin
    disp_nib = '0;
    if (owner_prog_q) begin
      disp_nib[nib_lsb(NIB_ADRS_LO) +: 8] = adrs_ext;
      disp_nib[nib_lsb(NIB_DATA_LO) +: 8] = data_ext;
    end else begin
      disp_nib[nib_lsb(NIB_ADRS_LO) +: 8] = resad_w;
      disp_nib[nib_lsb(NIB_DATA_LO) +: 8] = resdt;
    end
    disp_dp           = '0;
    disp_dp[DP_OWNER] = owner_prog_q;
    disp_dp[DP_FLASH] = (flash_q != '0);
  end

  assign resad      = resad_w;
  assign cpu_run_en = ~owner_prog_q;

endmodule

// File: tb/tb_prog_monitor_ctrl.sv
// Bench for prog_monitor_ctrl: behavioural model checked every cycle plus
// directed scenarios with literal expectations.
module tb_prog_monitor_ctrl;

  localparam int AW = 8, DW = 8, NRES = 4, DEB = 4, FLASH = 8;

  logic        clock = 1'b0, reset = 1'b1, mode = 1'b0;
  logic        step_btn_n = 1'b1, load_btn_n = 1'b1;
  logic [7:0]  data_sw = '0, resdt = '0, cpu_adrs = '0, cpu_data = '0;
  logic [1:0]  res_sel = '0;
  logic        cpu_wr_en = 1'b0;
  logic [7:0]  resad, mem_adrs, mem_data;
  logic        cpu_run_en, mem_wr_en;
  logic [15:0] disp_nib;
  logic [3:0]  disp_dp;

  prog_monitor_ctrl #(
    .AW(AW), .DW(DW), .NRES(NRES), .DEB_CYCLES(DEB), .FLASH_CYCLES(FLASH)
  ) dut (
    .clock(clock), .reset(reset), .mode(mode),
    .step_btn_n(step_btn_n), .load_btn_n(load_btn_n), .data_sw(data_sw),
    .res_sel(res_sel), .resdt(resdt), .cpu_adrs(cpu_adrs), .cpu_data(cpu_data),
    .cpu_wr_en(cpu_wr_en), .resad(resad), .cpu_run_en(cpu_run_en),
    .mem_adrs(mem_adrs), .mem_data(mem_data), .mem_wr_en(mem_wr_en),
    .disp_nib(disp_nib), .disp_dp(disp_dp)
  );

  always #5 clock = ~clock;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: buttons are seen through a 2-cycle delay; a level is accepted once
  // the last DEB delayed samples all disagree with the current accepted level.
  bit  m_on = 0;
  bit  raw [2];
  bit  m_s1 [2], m_s2 [2], m_acc [2], m_press [2], old_press [2];
  bit  hist [2][DEB];
  int  hfill [2];
  bit  m_mode_s1, m_mode_q, old_mode, settled;
  int  m_seq;                // 0 idle, 1 writing, 2 advancing
  int  m_adrs, m_wdata, m_flash;
  bit  m_owner;
  int  wr_cnt = 0, dp0_cnt = 0;
  logic [7:0] last_wa, last_wd;
  logic [15:0] e_nib;

  always @(posedge clock) begin
    raw[0] = step_btn_n;
    raw[1] = load_btn_n;
    if (reset) begin
      m_on = 1;
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 1; m_s2[b] = 1; m_acc[b] = 1; m_press[b] = 0; hfill[b] = 0;
      end
      m_mode_s1 = 0; m_mode_q = 0;
      m_seq = 0; m_adrs = 0; m_wdata = 0; m_flash = 0; m_owner = 0;
    end else begin
      old_press[0] = m_press[0];
      old_press[1] = m_press[1];
      old_mode     = m_mode_q;
      for (int b = 0; b < 2; b++) begin
        for (int i = DEB - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = m_s2[b];
        if (hfill[b] < DEB) hfill[b]++;
        settled = (hfill[b] == DEB);
        for (int i = 0; i < DEB; i++) if (hist[b][i] == m_acc[b]) settled = 0;
        m_press[b] = 0;
        if (settled) begin
          m_acc[b]   = ~m_acc[b];
          m_press[b] = !m_acc[b];
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
      m_mode_q  = m_mode_s1;
      m_mode_s1 = mode;
      if (m_flash > 0) m_flash--;
      if (m_seq == 0) begin
        m_owner = old_mode;
        if (old_mode) begin
          if (old_press[1]) m_adrs = data_sw;
          else if (old_press[0]) begin m_wdata = data_sw; m_seq = 1; end
        end
      end else if (m_seq == 1) begin
        m_seq = 2;
      end else begin
        m_adrs  = (m_adrs + 1) % 256;
        m_flash = FLASH;
        m_seq   = 0;
      end
    end
    #1;
    if (m_on) begin
      e_nib = m_owner ? {m_adrs[7:0], m_wdata[7:0]} : {6'b0, res_sel, resdt};
      chk("m_wr_en",  mem_wr_en,  m_owner ? (m_seq == 1) : cpu_wr_en);
      chk("m_adrs",   mem_adrs,   m_owner ? m_adrs[7:0] : cpu_adrs);
      chk("m_data",   mem_data,   m_owner ? m_wdata[7:0] : cpu_data);
      chk("m_run_en", cpu_run_en, !m_owner);
      chk("m_resad",  resad,      {6'b0, res_sel});
      chk("m_nib",    disp_nib,   e_nib);
      chk("m_dp",     disp_dp,    {m_owner, 2'b00, m_flash != 0});
      if (mem_wr_en && disp_dp[3]) begin wr_cnt++; last_wa = mem_adrs; last_wd = mem_data; end
      if (disp_dp[0]) dp0_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press_btn(input bit stp, input bit ld);
    if (stp) step_btn_n = 1'b0;
    if (ld)  load_btn_n = 1'b0;
    cyc(10);
    step_btn_n = 1'b1;
    load_btn_n = 1'b1;
    cyc(20);
  endtask

  int  wr0, dp0;
  bit  found;

  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("rst_wr_en",  mem_wr_en,  1'b0);
    chk("rst_run_en", cpu_run_en, 1'b1);
    chk("rst_dp",     disp_dp,    4'h0);
    chk("rst_nib",    disp_nib,   16'h0000);

    // single clean step press
    mode = 1'b1; cyc(4);
    data_sw = 8'h3C; wr0 = wr_cnt; dp0 = dp0_cnt;
    press_btn(1, 0);
    chk("t1_wr_cnt", wr_cnt - wr0, 1);
    chk("t1_wr_adrs", last_wa, 8'h00);
    chk("t1_wr_data", last_wd, 8'h3C);
    chk("t1_nib", disp_nib, 16'h013C);
    chk("t1_dp0_cycles", dp0_cnt - dp0, 8);
    chk("t1_owner_dp", disp_dp[3], 1'b1);

    // bouncing press gives one write
    data_sw = 8'h5A; wr0 = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      step_btn_n = 1'b0; cyc(2);
      step_btn_n = 1'b1; cyc(2);
    end
    press_btn(1, 0);
    chk("t2_wr_cnt", wr_cnt - wr0, 1);
    chk("t2_wr_adrs", last_wa, 8'h01);
    chk("t2_nib", disp_nib, 16'h025A);

    // load address FF then write, address wraps
    data_sw = 8'hFF;
    press_btn(0, 1);
    chk("t3_load_nib", disp_nib, 16'hFF5A);
    data_sw = 8'hA5; wr0 = wr_cnt;
    press_btn(1, 0);
    chk("t3_wr_cnt", wr_cnt - wr0, 1);
    chk("t3_wr_adrs", last_wa, 8'hFF);
    chk("t3_wr_data", last_wd, 8'hA5);
    chk("t3_wrap_nib", disp_nib, 16'h00A5);

    // both buttons together: load wins
    data_sw = 8'h10; wr0 = wr_cnt;
    press_btn(1, 1);
    chk("t4_wr_cnt", wr_cnt - wr0, 0);
    chk("t4_nib", disp_nib, 16'h10A5);

    // run mode: CPU owns the bus
    mode = 1'b0; cyc(5);
    cpu_wr_en = 1'b1; cpu_adrs = 8'h20; cpu_data = 8'h99; res_sel = 2'd1; resdt = 8'h7E;
    cyc(1);
    chk("t5_wr_en", mem_wr_en, 1'b1);
    chk("t5_adrs", mem_adrs, 8'h20);
    chk("t5_data", mem_data, 8'h99);
    chk("t5_run_en", cpu_run_en, 1'b1);
    chk("t5_resad", resad, 8'h01);
    chk("t5_nib", disp_nib, 16'h017E);
    chk("t5_dp", disp_dp, 4'h0);
    cpu_wr_en = 1'b0; wr0 = wr_cnt;
    press_btn(1, 0);
    chk("t5_no_wr", wr_cnt - wr0, 0);
    chk("t5_nib_after", disp_nib, 16'h017E);

    // reset in the write cycle aborts it
    res_sel = 2'd0; resdt = 8'h00;
    mode = 1'b1; cyc(5);
    data_sw = 8'hC3; step_btn_n = 1'b0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (mem_wr_en) found = 1;
    end
    chk("t6_wr_seen", found, 1'b1);
    chk("t6_wr_adrs", mem_adrs, 8'h10);
    chk("t6_wr_data", mem_data, 8'hC3);
    reset = 1'b1; step_btn_n = 1'b1;
    @(posedge clock); #1;
    chk("t6_wr_en", mem_wr_en, 1'b0);
    chk("t6_nib", disp_nib, 16'h0000);
    chk("t6_dp", disp_dp, 4'h0);
    chk("t6_run_en", cpu_run_en, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    cyc(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
